ppu_control_pipe: RTL and testbench

// Registered successor to the PPU decode control unit. Decodes a 32-bit MIPS instruction into the packed control word
// and carries it through a parametrised STAGES-deep control pipeline (EX/MEM/WB by default) with per-stage valid bits.

---
 rtl/ppu_control_pipe.sv | 72 +++++++
 tb/tb_ppu_control_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ppu_control_pipe.sv
// ppu_control_pipe: decodes MIPS instructions into control words and carries them down a STAGES-deep valid-tagged pipe.
// Optional illegal-opcode trap enabled by defining PPU_CTRL_ILLEGAL_TRAP_EN.
module ppu_control_pipe #(
  parameter int CW_WIDTH = 22,
  parameter int STAGES   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         instr_valid,
  input  logic [31:0]                  instruction,
  input  logic                         stall,
  input  logic                         flush,
  output logic [STAGES*CW_WIDTH-1:0]   ctrl_out,
  output logic [STAGES-1:0]            valid_out,
  output logic                         delay_slot_out,
  output logic                         illegal_instr
);
  typedef enum logic {NORMAL, DELAY_SLOT} state_t;
  state_t state;
  logic [5:0] op, fn;
  logic [4:0] rt;
  logic [21:0] dec;
  logic accept, ct, trap;
  logic [CW_WIDTH-1:0] cw [STAGES];
  always_comb begin
    op = instruction[31:26];
    rt = instruction[20:16];
    fn = instruction[5:0];
    dec = instruction == '0                 ? 22'h0 :
          op == 6'h09                       ? 22'h20300 :
          op == 6'h00 && fn == 6'h23        ? 22'h00900 :
          op == 6'h24                       ? 22'h20304 :
          op == 6'h28                       ? 22'h20014 :
          op == 6'h07                       ? 22'h05480 :
          op == 6'h01 && rt == 5'h01        ? 22'h04c80 :
          op == 6'h04                       ? 22'h00480 :
          op == 6'h03                       ? 22'h3de180 :
          op == 6'h00 && fn == 6'h08        ? 22'h280000 :
          op == 6'h0f                       ? 22'h2d900 : 22'h0;
    accept = instr_valid & ~stall & ~flush;
    ct = dec[21] | dec[10];
`ifdef PPU_CTRL_ILLEGAL_TRAP_EN
    trap = dec == '0 && instruction != '0;
`else
    trap = 1'b0;
`endif
  end
  // Downstream stages shift every edge; only stage0 reacts to stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) cw[k] <= '0;
      valid_out      <= '0;
      delay_slot_out <= 1'b0;
      illegal_instr  <= 1'b0;
      state          <= NORMAL;
    end else begin
      cw[0]          <= accept ? CW_WIDTH'(dec) : '0;
      valid_out[0]   <= accept;
      for (int k = 1; k < STAGES; k++) begin
        cw[k]        <= cw[k-1];
        valid_out[k] <= valid_out[k-1];
      end
      delay_slot_out <= accept && state == DELAY_SLOT;
      illegal_instr  <= accept & trap;
      if (flush) state <= NORMAL;
      else if (accept && !trap) state <= ct ? DELAY_SLOT : NORMAL;
    end
  end
  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign ctrl_out[g*CW_WIDTH +: CW_WIDTH] = cw[g];
  end
endmodule

// File: tb/tb_ppu_control_pipe.sv
// tb_ppu_control_pipe: directed vectors with a table-driven reference model checked every cycle.
module tb_ppu_control_pipe;
  localparam int W = 22;
  localparam int S = 3;
`ifdef PPU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] MASK  [10] = '{32'hfc000000, 32'hfc00003f, 32'hfc000000, 32'hfc000000, 32'hfc000000,
                                         32'hfc1f0000, 32'hfc000000, 32'hfc000000, 32'hfc00003f, 32'hfc000000};
  localparam logic [31:0] MATCH [10] = '{32'h24000000, 32'h00000023, 32'h90000000, 32'ha0000000, 32'h1c000000,
                                         32'h04010000, 32'h10000000, 32'h0c000000, 32'h00000008, 32'h3c000000};
  localparam logic [21:0] WORD  [10] = '{22'h20300, 22'h00900, 22'h20304, 22'h20014, 22'h05480,
                                         22'h04c80, 22'h00480, 22'h3de180, 22'h280000, 22'h2d900};
  localparam logic [31:0] ADDIU = 32'h24010005;

  logic clk = 0, rst_n = 1, instr_valid = 0, stall = 0, flush = 0;
  logic [31:0] instruction = '0;
  logic [S*W-1:0] ctrl_out;
  logic [S-1:0] valid_out;
  logic delay_slot_out, illegal_instr;
  int total = 0, bad = 0;

  ppu_control_pipe #(.CW_WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
    .stall(stall), .flush(flush), .ctrl_out(ctrl_out), .valid_out(valid_out),
    .delay_slot_out(delay_slot_out), .illegal_instr(illegal_instr));

  always #5 clk = ~clk;

  function automatic logic [21:0] ref_dec(input logic [31:0] i);
    for (int k = 0; k < 10; k++) if ((i & MASK[k]) == MATCH[k]) return WORD[k];
    return 22'h0;
  endfunction

  logic [W-1:0] m_cw [S];
  logic [S-1:0] m_v;
  logic m_ds, m_ill, m_slot, m_acc, m_illg;
  logic [21:0] m_w;
  logic [S*W-1:0] m_pk;

  always_comb begin
    m_acc  = instr_valid & ~stall & ~flush;
    m_w    = ref_dec(instruction);
    m_illg = instruction != '0 && m_w == '0;
    m_pk   = '0;
    for (int k = 0; k < S; k++) m_pk[k*W +: W] = m_cw[k];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) m_cw[k] <= '0;
      m_v <= '0; m_ds <= 0; m_ill <= 0; m_slot <= 0;
    end else begin
      m_cw[0] <= m_acc ? m_w : '0;
      for (int k = 1; k < S; k++) m_cw[k] <= m_cw[k-1];
      m_v   <= {m_v[S-2:0], m_acc};
      m_ds  <= m_acc & m_slot;
      m_ill <= TRAP & m_acc & m_illg;
      if (flush) m_slot <= 1'b0;
      else if (m_acc && !(TRAP && m_illg)) m_slot <= m_w[21] | m_w[10];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("cmp_ctrl", 128'(ctrl_out), 128'(m_pk));
    chk("cmp_valid", 128'(valid_out), 128'(m_v));
    chk("cmp_ds", 128'(delay_slot_out), 128'(m_ds));
    chk("cmp_ill", 128'(illegal_instr), 128'(m_ill));
  end

  task automatic drv(input logic iv, input logic [31:0] i, input logic st = 0, input logic fl = 0);
    instr_valid = iv; instruction = i; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 0;
    #1 chk("rst_ctrl", 128'(ctrl_out), 0);
    chk("rst_valid", 128'(valid_out), 0);
    chk("rst_flags", {delay_slot_out, illegal_instr}, 0);
    @(posedge clk); #1 rst_n = 1;
    drv(1, ADDIU);
    chk("addiu_s0", ctrl_out[21:0], 22'h20300); chk("addiu_v0", valid_out, 3'b001);
    drv(0, 0);
    chk("addiu_s1", ctrl_out[43:22], 22'h20300); chk("addiu_v1", valid_out, 3'b010);
    drv(0, 0);
    chk("addiu_s2", ctrl_out[65:44], 22'h20300); chk("addiu_v2", valid_out, 3'b100);
    drv(1, 32'h0c000010);
    chk("jal_w", ctrl_out[21:0], 22'h3de180); chk("jal_ds", delay_slot_out, 0);
    drv(1, 32'h00221823);
    chk("subu_w", ctrl_out[21:0], 22'h00900); chk("subu_ds", delay_slot_out, 1);
    drv(1, ADDIU);
    chk("after_slot_ds", delay_slot_out, 0);
    drv(1, 32'h90220000, 1);
    chk("stall1_v0", valid_out[0], 0);
    drv(1, 32'h90220000, 1);
    chk("stall2_v0", valid_out[0], 0);
    drv(1, 32'h90220000);
    chk("lbu_w", ctrl_out[21:0], 22'h20304); chk("lbu_v0", valid_out[0], 1);
    drv(1, 32'h1c200004);
    chk("bgtz_w", ctrl_out[21:0], 22'h05480);
    drv(1, ADDIU, 0, 1);
    chk("flush_v0", valid_out[0], 0);
    drv(1, ADDIU);
    chk("flush_ds", delay_slot_out, 0);
    drv(1, 32'h04210008);
    chk("bgez_w", ctrl_out[21:0], 22'h04c80);
    drv(1, ADDIU);
    chk("bgez_ds", delay_slot_out, 1);
    drv(1, 32'h04200008);
    chk("rt0_w", ctrl_out[21:0], 0); chk("rt0_v", valid_out[0], 1);
    chk("rt0_ill", illegal_instr, TRAP);
    drv(1, 32'h03e00008);
    chk("jr_w", ctrl_out[21:0], 22'h280000);
    drv(1, 32'h3c011234);
    chk("lui_w", ctrl_out[21:0], 22'h2d900); chk("lui_ds", delay_slot_out, 1);
    drv(1, 32'h10000003);
    chk("beq_w", ctrl_out[21:0], 22'h00480);
    drv(1, 32'h10000003);
    chk("beq2_ds", delay_slot_out, 1);
    drv(1, ADDIU);
    chk("beq3_ds", delay_slot_out, 1);
    drv(1, ADDIU);
    chk("beq4_ds", delay_slot_out, 0);
    drv(1, 32'h10000003);
    drv(1, ADDIU, 1, 1);
    chk("stflush_v0", valid_out[0], 0);
    drv(1, ADDIU);
    chk("stflush_ds", delay_slot_out, 0);
    drv(1, 32'h10000003);
    drv(1, ADDIU, 1);
    drv(0, 0);
    chk("hold_v0", valid_out[0], 0);
    drv(1, ADDIU);
    chk("hold_ds", delay_slot_out, 1);
    drv(1, 32'ha0220000);
    chk("sb_w", ctrl_out[21:0], 22'h20014);
    drv(1, 32'hfc000000);
    chk("op3f_w", ctrl_out[21:0], 0); chk("op3f_v", valid_out[0], 1);
    chk("op3f_ill", illegal_instr, TRAP);
    drv(1, 32'h0);
    chk("nop_ill", illegal_instr, 0); chk("nop_v", valid_out[0], 1);
    drv(1, ADDIU); drv(1, ADDIU); drv(1, ADDIU);
    chk("full_v", valid_out, 3'b111);
    #2 rst_n = 0;
    #1 chk("async_ctrl", 128'(ctrl_out), 0);
    chk("async_valid", 128'(valid_out), 0);
    chk("async_flags", {delay_slot_out, illegal_instr}, 0);
    #3 rst_n = 1;
    instr_valid = 0;
    @(posedge clk); #1;
    drv(1, ADDIU);
    chk("post_rst_w", ctrl_out[21:0], 22'h20300); chk("post_rst_v", valid_out, 3'b001);
    repeat (4) drv(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
